// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg
// Shared definitions for the ID/EX issue stage: datapath widths, RV32
// opcode constants, ALU control encodings, the decoded-control and EX
// pipeline-register structures, and the decode helpers that turn raw
// instruction fields into ALU/memory/branch controls.
package alu_issue_stage_pkg;

  localparam int CPU_WIDTH      = 32;
  localparam int ALU_CTRL_WIDTH = 4;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [ALU_CTRL_WIDTH-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_ctrl;
    logic    use_imm;
    logic    regwrite;
    logic    memread;
    logic    memwrite;
    logic    branch;
    logic    illegal;
  } dec_ctrl_t;

  typedef struct packed {
    logic                 valid;
    dec_ctrl_t            ctrl;
    logic [4:0]           rd;
    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic [CPU_WIDTH-1:0] rs1_data;
    logic [CPU_WIDTH-1:0] rs2_data;
    logic [CPU_WIDTH-1:0] imm;
  } ex_reg_t;

  // Control word of a bubble: nothing is written, nothing is accessed, and
  // the ALU idles on ADD so the reset and bubble encodings are identical.
  function automatic dec_ctrl_t ctrl_idle();
    dec_ctrl_t c;
    c          = '0;
    c.alu_ctrl = ALU_ADD;
    return c;
  endfunction

  function automatic ex_reg_t ex_bubble();
    ex_reg_t e;
    e      = '0;
    e.ctrl = ctrl_idle();
    return e;
  endfunction

  // Only these formats really read rs2; for I-ALU and loads the rs2 field
  // holds immediate bits and must not raise a false load-use hazard.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  endfunction

  // Unsupported opcode/funct combinations fall back to an idle ADD with
  // only the illegal flag raised. Invalid slots carry no control at all,
  // and writes to x0 are dropped here so later stages never see them.
  function automatic dec_ctrl_t decode(input logic       valid,
                                       input logic [6:0] opcode,
                                       input logic [2:0] funct3,
                                       input logic       funct7_b5,
                                       input logic [4:0] rd);
    dec_ctrl_t c;
    c = ctrl_idle();
    unique case (opcode)
      OP_RTYPE: begin
        c.regwrite = 1'b1;
        unique case (funct3)
          3'b000:  c.alu_ctrl = funct7_b5 ? ALU_SUB : ALU_ADD;
          3'b111:  c.alu_ctrl = ALU_AND;
          3'b110:  c.alu_ctrl = ALU_OR;
          default: begin
            c         = ctrl_idle();
            c.illegal = 1'b1;
          end
        endcase
      end
      OP_IALU: begin
        c.regwrite = 1'b1;
        c.use_imm  = 1'b1;
        unique case (funct3)
          3'b000:  c.alu_ctrl = ALU_ADD;
          3'b111:  c.alu_ctrl = ALU_AND;
          3'b110:  c.alu_ctrl = ALU_OR;
          default: begin
            c         = ctrl_idle();
            c.illegal = 1'b1;
          end
        endcase
      end
      OP_LOAD: begin
        c.use_imm  = 1'b1;
        c.memread  = 1'b1;
        c.regwrite = 1'b1;
      end
      OP_STORE: begin
        c.use_imm  = 1'b1;
        c.memwrite = 1'b1;
      end
      OP_BRANCH: begin
        c.alu_ctrl = ALU_SUB;
        c.branch   = 1'b1;
      end
      default: c.illegal = 1'b1;
    endcase
    if (!valid) begin
      c = ctrl_idle();
    end
    if (rd == 5'd0) begin
      c.regwrite = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_issue_stage_fwd_mux.sv
// alu_issue_stage_fwd_mux
// Operand forwarding selector for one source register.
// Ports:
//   i_rs_addr / i_rs_data        registered source index and register value
//   i_exm_rd/_regwrite/_result   EX/MEM writeback (highest priority)
//   i_wb_rd/_regwrite/_result    MEM/WB writeback
//   o_value                      selected operand
module alu_issue_stage_fwd_mux
  import alu_issue_stage_pkg::*;
(
  input  logic [4:0]           i_rs_addr,
  input  logic [CPU_WIDTH-1:0] i_rs_data,
  input  logic [4:0]           i_exm_rd,
  input  logic                 i_exm_regwrite,
  input  logic [CPU_WIDTH-1:0] i_exm_result,
  input  logic [4:0]           i_wb_rd,
  input  logic                 i_wb_regwrite,
  input  logic [CPU_WIDTH-1:0] i_wb_result,
  output logic [CPU_WIDTH-1:0] o_value
);

  logic w_exm_hit;
  logic w_wb_hit;

  // A producer matches only if it really writes a non-zero register, so
  // x0 reads always come from the register file.
  assign w_exm_hit = i_exm_regwrite && (i_exm_rd != 5'd0) && (i_exm_rd == i_rs_addr);
  assign w_wb_hit  = i_wb_regwrite  && (i_wb_rd  != 5'd0) && (i_wb_rd  == i_rs_addr);

  // The younger EX/MEM result shadows the older MEM/WB one.
  always_comb begin
    o_value = i_rs_data;
    if (w_exm_hit) begin
      o_value = i_exm_result;
    end else if (w_wb_hit) begin
      o_value = i_wb_result;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// ID/EX pipeline boundary: decodes and registers the ID instruction,
// drives ALU operands and control, forwards results from EX/MEM and
// MEM/WB, and requests an IF/ID hold on a load-use hazard.
// Ports:
//   i_clk, i_rst                  clock, async active-high reset
//   i_id_*                        decoded ID fields and register reads
//   i_stall, i_flush              freeze / kill the instruction entering EX
//   i_exm_*, i_wb_*               writeback info for forwarding
//   o_data_in_1/2, o_alu_ctrl     ALU operands and opcode
//   o_ex_*                        EX-stage control, destination, store data
//   o_id_hold                     load-use stall request
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_id_valid,
  input  logic [6:0]                i_id_opcode,
  input  logic [2:0]                i_id_funct3,
  input  logic                      i_id_funct7_b5,
  input  logic [4:0]                i_id_rs1_addr,
  input  logic [4:0]                i_id_rs2_addr,
  input  logic [4:0]                i_id_rd_addr,
  input  logic [CPU_WIDTH-1:0]      i_id_rs1_data,
  input  logic [CPU_WIDTH-1:0]      i_id_rs2_data,
  input  logic [CPU_WIDTH-1:0]      i_id_imm,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic [4:0]                i_exm_rd,
  input  logic                      i_exm_regwrite,
  input  logic [CPU_WIDTH-1:0]      i_exm_result,
  input  logic [4:0]                i_wb_rd,
  input  logic                      i_wb_regwrite,
  input  logic [CPU_WIDTH-1:0]      i_wb_result,
  output logic [CPU_WIDTH-1:0]      o_data_in_1,
  output logic [CPU_WIDTH-1:0]      o_data_in_2,
  output logic [ALU_CTRL_WIDTH-1:0] o_alu_ctrl,
  output logic                      o_ex_valid,
  output logic                      o_ex_regwrite,
  output logic                      o_ex_memread,
  output logic                      o_ex_memwrite,
  output logic                      o_ex_branch,
  output logic                      o_ex_illegal,
  output logic [4:0]                o_ex_rd,
  output logic [CPU_WIDTH-1:0]      o_ex_store_data,
  output logic                      o_id_hold
);

  ex_reg_t              r_ex;
  dec_ctrl_t            w_dec;
  ex_reg_t              w_ex_next;
  logic                 w_id_hold;
  logic [CPU_WIDTH-1:0] w_fwd_rs1;
  logic [CPU_WIDTH-1:0] w_fwd_rs2;

  assign w_dec = decode(i_id_valid, i_id_opcode, i_id_funct3, i_id_funct7_b5, i_id_rd_addr);

  always_comb begin
    w_ex_next          = ex_bubble();
    w_ex_next.valid    = i_id_valid;
    w_ex_next.ctrl     = w_dec;
    w_ex_next.rd       = i_id_rd_addr;
    w_ex_next.rs1_addr = i_id_rs1_addr;
    w_ex_next.rs2_addr = i_id_rs2_addr;
    w_ex_next.rs1_data = i_id_rs1_data;
    w_ex_next.rs2_data = i_id_rs2_data;
    w_ex_next.imm      = i_id_imm;
  end

  // The loaded value is not available until MEM/WB, so a consumer right
  // behind a load must wait one cycle in ID while EX takes a bubble.
  assign w_id_hold = i_id_valid && r_ex.valid && r_ex.ctrl.memread && (r_ex.rd != 5'd0) &&
                     ((r_ex.rd == i_id_rs1_addr) ||
                      ((r_ex.rd == i_id_rs2_addr) && uses_rs2(i_id_opcode)));

  // Flush beats stall so a killed instruction never survives a freeze;
  // stall beats the load-use bubble so the load stays in EX and the hold
  // request persists until it actually advances.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ex <= ex_bubble();
    end else if (i_flush) begin
      r_ex <= ex_bubble();
    end else if (i_stall) begin
      r_ex <= r_ex;
    end else if (w_id_hold) begin
      r_ex <= ex_bubble();
    end else begin
      r_ex <= w_ex_next;
    end
  end

  alu_issue_stage_fwd_mux u_fwd_mux_rs1 (
    .i_rs_addr      (r_ex.rs1_addr),
    .i_rs_data      (r_ex.rs1_data),
    .i_exm_rd       (i_exm_rd),
    .i_exm_regwrite (i_exm_regwrite),
    .i_exm_result   (i_exm_result),
    .i_wb_rd        (i_wb_rd),
    .i_wb_regwrite  (i_wb_regwrite),
    .i_wb_result    (i_wb_result),
    .o_value        (w_fwd_rs1)
  );

  alu_issue_stage_fwd_mux u_fwd_mux_rs2 (
    .i_rs_addr      (r_ex.rs2_addr),
    .i_rs_data      (r_ex.rs2_data),
    .i_exm_rd       (i_exm_rd),
    .i_exm_regwrite (i_exm_regwrite),
    .i_exm_result   (i_exm_result),
    .i_wb_rd        (i_wb_rd),
    .i_wb_regwrite  (i_wb_regwrite),
    .i_wb_result    (i_wb_result),
    .o_value        (w_fwd_rs2)
  );

  // Stores use the immediate for the address, so their data is taken
  // from the forwarded rs2 path independently of the ALU operand.
  assign o_data_in_1     = w_fwd_rs1;
  assign o_data_in_2     = r_ex.ctrl.use_imm ? r_ex.imm : w_fwd_rs2;
  assign o_ex_store_data = w_fwd_rs2;
  assign o_alu_ctrl      = r_ex.ctrl.alu_ctrl;
  assign o_ex_valid      = r_ex.valid;
  assign o_ex_regwrite   = r_ex.ctrl.regwrite;
  assign o_ex_memread    = r_ex.ctrl.memread;
  assign o_ex_memwrite   = r_ex.ctrl.memwrite;
  assign o_ex_branch     = r_ex.ctrl.branch;
  assign o_ex_illegal    = r_ex.ctrl.illegal;
  assign o_ex_rd         = r_ex.rd;
  assign o_id_hold       = w_id_hold;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
// Directed scoreboard bench for alu_issue_stage. Each cycle the stimulus
// drives ID and writeback inputs shortly after the rising edge and queues
// the EX-side outputs it expects for that cycle; a monitor pops and
// compares on every falling edge.
module tb_alu_issue_stage;

  localparam logic [3:0] cAnd = 4'b0000;
  localparam logic [3:0] cOr  = 4'b0001;
  localparam logic [3:0] cAdd = 4'b0010;
  localparam logic [3:0] cSub = 4'b0110;

  localparam logic [6:0] opR  = 7'b0110011;
  localparam logic [6:0] opI  = 7'b0010011;
  localparam logic [6:0] opLd = 7'b0000011;
  localparam logic [6:0] opSt = 7'b0100011;
  localparam logic [6:0] opBr = 7'b1100011;
  localparam logic [6:0] opBad = 7'b1111111;

  logic        clk;
  logic        rst;
  logic        idValid;
  logic [6:0]  idOpcode;
  logic [2:0]  idFunct3;
  logic        idFunct7b5;
  logic [4:0]  idRs1, idRs2, idRd;
  logic [31:0] idRs1Data, idRs2Data, idImm;
  logic        stall, flush;
  logic [4:0]  exmRd, wbRd;
  logic        exmRw, wbRw;
  logic [31:0] exmRes, wbRes;
  logic [31:0] dataIn1, dataIn2, storeData;
  logic [3:0]  aluCtrl;
  logic        exValid, exRw, exMr, exMw, exBr, exIll, idHold;
  logic [4:0]  exRd;

  typedef struct {
    string       nm;
    logic [111:0] vec;
  } expT;

  expT q[$];
  int  checks = 0;
  int  errors = 0;

  alu_issue_stage dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_id_valid      (idValid),
    .i_id_opcode     (idOpcode),
    .i_id_funct3     (idFunct3),
    .i_id_funct7_b5  (idFunct7b5),
    .i_id_rs1_addr   (idRs1),
    .i_id_rs2_addr   (idRs2),
    .i_id_rd_addr    (idRd),
    .i_id_rs1_data   (idRs1Data),
    .i_id_rs2_data   (idRs2Data),
    .i_id_imm        (idImm),
    .i_stall         (stall),
    .i_flush         (flush),
    .i_exm_rd        (exmRd),
    .i_exm_regwrite  (exmRw),
    .i_exm_result    (exmRes),
    .i_wb_rd         (wbRd),
    .i_wb_regwrite   (wbRw),
    .i_wb_result     (wbRes),
    .o_data_in_1     (dataIn1),
    .o_data_in_2     (dataIn2),
    .o_alu_ctrl      (aluCtrl),
    .o_ex_valid      (exValid),
    .o_ex_regwrite   (exRw),
    .o_ex_memread    (exMr),
    .o_ex_memwrite   (exMw),
    .o_ex_branch     (exBr),
    .o_ex_illegal    (exIll),
    .o_ex_rd         (exRd),
    .o_ex_store_data (storeData),
    .o_id_hold       (idHold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs fields as {valid,rw,mr,mw,br,ill,rd,ctrl,d1,d2,sd,hold}.
  function automatic logic [111:0] packExp(input logic v, rw, mr, mw, br, ill,
                                           input logic [4:0] rd, input logic [3:0] ctrl,
                                           input logic [31:0] d1, d2, sd, input logic hold);
    return {v, rw, mr, mw, br, ill, rd, ctrl, d1, d2, sd, hold};
  endfunction

  task automatic checkOutput(input expT e);
    logic [111:0] act;
    act = packExp(exValid, exRw, exMr, exMw, exBr, exIll, exRd, aluCtrl,
                  dataIn1, dataIn2, storeData, idHold);
    checks++;
    if (act !== e.vec) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", e.nm, act, e.vec);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      checkOutput(q.pop_front());
    end
  end

  task automatic setId(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic b5, input logic [4:0] rs1, rs2, rd,
                       input logic [31:0] d1, d2, imm);
    idValid = v; idOpcode = op; idFunct3 = f3; idFunct7b5 = b5;
    idRs1 = rs1; idRs2 = rs2; idRd = rd;
    idRs1Data = d1; idRs2Data = d2; idImm = imm;
  endtask

  task automatic setFwd(input logic [4:0] eRd, input logic eRw, input logic [31:0] eRes,
                        input logic [4:0] wRd, input logic wRw, input logic [31:0] wRes);
    exmRd = eRd; exmRw = eRw; exmRes = eRes;
    wbRd = wRd; wbRw = wRw; wbRes = wRes;
  endtask

  // Queues what this cycle's outputs must be, then moves to just after
  // the next rising edge where the following cycle's inputs are driven.
  task automatic applyStimulus(input string nm, input logic [111:0] vec);
    expT e;
    e.nm  = nm;
    e.vec = vec;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  logic [111:0] resetVec;

  initial begin
    resetVec = packExp(0,0,0,0,0,0, 5'd0, cAdd, 32'h0, 32'h0, 32'h0, 0);
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    setId(0, 7'h0, 3'h0, 0, 0, 0, 0, 0, 0, 0);
    setFwd(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    applyStimulus("reset", resetVec);

    rst = 1'b0;
    setId(1, opR, 3'b000, 0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
    applyStimulus("empty_after_reset", resetVec);

    setId(1, opR, 3'b000, 1, 5'd3, 5'd1, 5'd4, 32'd0, 32'd5, 32'd0);
    applyStimulus("add_x3", packExp(1,1,0,0,0,0, 5'd3, cAdd, 32'd5, 32'd7, 32'd7, 0));

    setId(1, opR, 3'b000, 0, 5'd3, 5'd3, 5'd7, 32'd0, 32'd0, 32'd0);
    setFwd(5'd3, 1, 32'd12, 5'd0, 0, 32'd0);
    applyStimulus("sub_fwd_exm", packExp(1,1,0,0,0,0, 5'd4, cSub, 32'd12, 32'd5, 32'd5, 0));

    setId(1, opR, 3'b000, 0, 5'd0, 5'd2, 5'd9, 32'h11, 32'd7, 32'd0);
    setFwd(5'd3, 1, 32'd9, 5'd3, 1, 32'd4);
    applyStimulus("exm_over_wb", packExp(1,1,0,0,0,0, 5'd7, cAdd, 32'd9, 32'd9, 32'd9, 0));

    setId(1, opLd, 3'b010, 0, 5'd1, 5'd0, 5'd5, 32'h100, 32'd0, 32'd8);
    setFwd(5'd0, 1, 32'hAA, 5'd2, 1, 32'hDD);
    applyStimulus("x0_not_fwd_wb_fwd", packExp(1,1,0,0,0,0, 5'd9, cAdd, 32'h11, 32'hDD, 32'hDD, 0));

    setId(1, opR, 3'b000, 0, 5'd5, 5'd2, 5'd6, 32'd0, 32'd7, 32'd0);
    setFwd(0, 0, 0, 0, 0, 0);
    applyStimulus("load_use_hold", packExp(1,1,1,0,0,0, 5'd5, cAdd, 32'h100, 32'd8, 32'd0, 1));

    setFwd(5'd5, 1, 32'h55, 5'd0, 0, 32'd0);
    applyStimulus("load_use_bubble", resetVec);

    setId(1, opI, 3'b110, 0, 5'd1, 5'd0, 5'd10, 32'h0F, 32'd0, 32'hF0);
    setFwd(5'd0, 0, 32'd0, 5'd5, 1, 32'h55);
    applyStimulus("add_after_load_wb_fwd", packExp(1,1,0,0,0,0, 5'd6, cAdd, 32'h55, 32'd7, 32'd7, 0));

    setId(1, opBad, 3'b000, 0, 5'd0, 5'd0, 5'd11, 32'd0, 32'd0, 32'd0);
    setFwd(0, 0, 0, 0, 0, 0);
    applyStimulus("ori", packExp(1,1,0,0,0,0, 5'd10, cOr, 32'h0F, 32'hF0, 32'd0, 0));

    setId(1, opR, 3'b111, 0, 5'd1, 5'd2, 5'd12, 32'hFF, 32'h0F, 32'd0);
    applyStimulus("illegal", packExp(1,0,0,0,0,1, 5'd11, cAdd, 32'd0, 32'd0, 32'd0, 0));

    setId(1, opSt, 3'b010, 0, 5'd1, 5'd2, 5'd4, 32'h200, 32'h77, 32'd4);
    stall = 1'b1; flush = 1'b1;
    applyStimulus("and", packExp(1,1,0,0,0,0, 5'd12, cAnd, 32'hFF, 32'h0F, 32'h0F, 0));

    stall = 1'b0; flush = 1'b0;
    applyStimulus("flush_beats_stall", resetVec);

    setId(1, opBr, 3'b000, 0, 5'd1, 5'd2, 5'd0, 32'd3, 32'd3, 32'd0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("store_stall_%0d", i),
                    packExp(1,0,0,1,0,0, 5'd4, cAdd, 32'h200, 32'd4, 32'h77, 0));
    end
    stall = 1'b0;
    applyStimulus("store_after_stall", packExp(1,0,0,1,0,0, 5'd4, cAdd, 32'h200, 32'd4, 32'h77, 0));

    setId(1, opLd, 3'b010, 0, 5'd0, 5'd0, 5'd13, 32'd0, 32'd0, 32'd0);
    applyStimulus("branch", packExp(1,0,0,0,1,0, 5'd0, cSub, 32'd3, 32'd3, 32'd3, 0));

    setId(1, opR, 3'b000, 0, 5'd13, 5'd13, 5'd14, 32'd5, 32'd5, 32'd0);
    stall = 1'b1;
    applyStimulus("stall_with_hold", packExp(1,1,1,0,0,0, 5'd13, cAdd, 32'd0, 32'd0, 32'd0, 1));

    stall = 1'b0;
    applyStimulus("hold_persists", packExp(1,1,1,0,0,0, 5'd13, cAdd, 32'd0, 32'd0, 32'd0, 1));

    applyStimulus("hold_bubble", resetVec);

    setId(1, opR, 3'b000, 0, 5'd1, 5'd2, 5'd15, 32'd1, 32'd2, 32'd0);
    applyStimulus("add_x14", packExp(1,1,0,0,0,0, 5'd14, cAdd, 32'd5, 32'd5, 32'd5, 0));

    #1 rst = 1'b1;
    applyStimulus("async_reset", resetVec);

    rst = 1'b0;
    setId(1, opR, 3'b110, 0, 5'd1, 5'd2, 5'd16, 32'hF0, 32'h0F, 32'd0);
    applyStimulus("after_reset_release", resetVec);

    setId(0, 7'h0, 3'h0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("or_first_capture", packExp(1,1,0,0,0,0, 5'd16, cOr, 32'hF0, 32'h0F, 32'h0F, 0));

    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
